// File: rtl/data_memory_responder.sv
// Data-memory responder for the MEM stage: accepts one load/store, waits a
// fixed number of cycles, then commits the access against a byte-addressed,
// big-endian RAM and returns a one-cycle ready pulse.
//
// state  | meaning
// IDLE   | no access outstanding; a request is accepted here
// WAIT   | access latched, counting down wait states
// RESP   | access committed on entry; ready high for this one cycle
module data_memory_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic        i_mem_write,
  input  logic        i_byte_access,
  input  logic [31:0] i_address,
  input  logic [31:0] i_write_data,
  output logic [31:0] o_read_data,
  output logic        o_ready,
  output logic        o_stall,
  output logic        o_addr_error
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_we;
  logic        r_byte;
  logic        r_err;
  logic [31:0] r_read_data;
  logic [7:0]  r_mem [DEPTH];

  logic [31:0]   w_cur_addr;
  logic [31:0]   w_cur_wdata;
  logic          w_cur_we;
  logic          w_cur_byte;
  logic          w_commit;
  logic          w_oob;
  logic [AW-1:0] w_idx;
  logic [AW-1:0] w_b0;
  logic [AW-1:0] w_b1;
  logic [AW-1:0] w_b2;
  logic [AW-1:0] w_b3;
  logic [31:0]   w_rdata;

  // With zero wait states the commit happens on the acceptance edge, so the
  // access must be taken straight from the inputs while still in IDLE.
  assign w_cur_addr  = (r_state == S_IDLE) ? i_address     : r_addr;
  assign w_cur_wdata = (r_state == S_IDLE) ? i_write_data  : r_wdata;
  assign w_cur_we    = (r_state == S_IDLE) ? i_mem_write   : r_we;
  assign w_cur_byte  = (r_state == S_IDLE) ? i_byte_access : r_byte;

  assign w_commit = (w_next == S_RESP) && (r_state != S_RESP);
  assign w_oob    = (w_cur_addr >= 32'(DEPTH));

  // Word accesses drop the two low address bits; byte lanes are big-endian.
  assign w_idx = w_cur_addr[AW-1:0];
  assign w_b0  = {w_idx[AW-1:2], 2'd0};
  assign w_b1  = {w_idx[AW-1:2], 2'd1};
  assign w_b2  = {w_idx[AW-1:2], 2'd2};
  assign w_b3  = {w_idx[AW-1:2], 2'd3};

  assign w_rdata = w_cur_byte ? {24'd0, r_mem[w_idx]}
                              : {r_mem[w_b0], r_mem[w_b1], r_mem[w_b2], r_mem[w_b3]};

  // Next-state selection.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (i_req) w_next = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
      S_WAIT: if (r_cnt == 4'd1) w_next = S_RESP;
      S_RESP: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State, request latch, wait counter and registered load result.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_we        <= 1'b0;
      r_byte      <= 1'b0;
      r_err       <= 1'b0;
      r_read_data <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && i_req) begin
        r_addr  <= i_address;
        r_wdata <= i_write_data;
        r_we    <= i_mem_write;
        r_byte  <= i_byte_access;
        r_cnt   <= 4'(WAIT_STATES);
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_commit) begin
        r_err <= w_oob;
        if (!w_cur_we) r_read_data <= w_oob ? 32'd0 : w_rdata;
      end
    end
  end

  // RAM write port; out-of-range stores are dropped, contents survive reset.
  always_ff @(posedge clk) begin
    if (!reset && w_commit && w_cur_we && !w_oob) begin
      if (w_cur_byte) begin
        r_mem[w_idx] <= w_cur_wdata[7:0];
      end else begin
        r_mem[w_b0] <= w_cur_wdata[31:24];
        r_mem[w_b1] <= w_cur_wdata[23:16];
        r_mem[w_b2] <= w_cur_wdata[15:8];
        r_mem[w_b3] <= w_cur_wdata[7:0];
      end
    end
  end

  assign o_read_data  = r_read_data;
  assign o_ready      = (r_state == S_RESP);
  assign o_addr_error = (r_state == S_RESP) && r_err;
  assign o_stall      = ((r_state == S_IDLE) && i_req) || (r_state == S_WAIT);

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: two instances (2 and 0 wait states) share
// one stimulus stream; each has its own transaction-level model.
module tb_data_memory_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        mem_write;
  logic        byte_access;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] rd0, rd1;
  logic [1:0]  rdy, stl, aerr;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  data_memory_responder #(.DEPTH(256), .WAIT_STATES(2)) dut_a (
    .clk(clk), .reset(reset), .i_req(req), .i_mem_write(mem_write),
    .i_byte_access(byte_access), .i_address(address), .i_write_data(write_data),
    .o_read_data(rd0), .o_ready(rdy[0]), .o_stall(stl[0]), .o_addr_error(aerr[0]));

  data_memory_responder #(.DEPTH(256), .WAIT_STATES(0)) dut_b (
    .clk(clk), .reset(reset), .i_req(req), .i_mem_write(mem_write),
    .i_byte_access(byte_access), .i_address(address), .i_write_data(write_data),
    .o_read_data(rd1), .o_ready(rdy[1]), .o_stall(stl[1]), .o_addr_error(aerr[1]));

  // ---------------- behavioural model ----------------
  // phase: 0 = idle, 1 = access outstanding, 2 = completion cycle
  int          ws [2] = '{2, 0};
  logic [7:0]  mm [2][256];
  int          phase [2] = '{0, 0};
  int          left [2] = '{0, 0};
  logic [31:0] l_addr [2];
  logic [31:0] l_wd [2];
  logic        l_we [2];
  logic        l_byt [2];
  logic        l_oob [2] = '{1'b0, 1'b0};
  logic [31:0] exp_rd [2] = '{32'd0, 32'd0};

  task automatic commit(input int i);
    int a;
    l_oob[i] = (l_addr[i] >= 32'd256);
    a = int'(l_addr[i][7:0]);
    if (!l_byt[i]) a = a - (a % 4);
    if (l_we[i]) begin
      if (!l_oob[i]) begin
        if (l_byt[i]) mm[i][a] = l_wd[i][7:0];
        else for (int b = 0; b < 4; b++) mm[i][a+b] = l_wd[i][31-8*b -: 8];
      end
    end else if (l_oob[i]) begin
      exp_rd[i] = 32'd0;
    end else if (l_byt[i]) begin
      exp_rd[i] = {24'd0, mm[i][a]};
    end else begin
      exp_rd[i] = {mm[i][a], mm[i][a+1], mm[i][a+2], mm[i][a+3]};
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        phase[i] = 0;
        exp_rd[i] = 32'd0;
        l_oob[i] = 1'b0;
      end else if (phase[i] == 0) begin
        if (req) begin
          l_addr[i] = address; l_wd[i] = write_data;
          l_we[i] = mem_write; l_byt[i] = byte_access;
          left[i] = ws[i];
          if (left[i] == 0) begin commit(i); phase[i] = 2; end
          else phase[i] = 1;
        end
      end else if (phase[i] == 1) begin
        left[i]--;
        if (left[i] == 0) begin commit(i); phase[i] = 2; end
      end else begin
        phase[i] = 0;
      end
    end
  end

  task automatic check(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] actual=%h required=%h at %0t", nm, i, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        check("ready", i, 32'(rdy[i]), 32'(phase[i] == 2));
        check("stall", i, 32'(stl[i]), 32'((phase[i] == 0 && req) || phase[i] == 1));
        check("addr_error", i, 32'(aerr[i]), 32'(phase[i] == 2 && l_oob[i]));
        check("read_data", i, (i == 0) ? rd0 : rd1, exp_rd[i]);
      end
    end
  end

  // ---------------- directed helpers ----------------
  // Called at #1 after a rising edge with both instances idle.
  task automatic op(input logic we, input logic byt, input logic [31:0] a, input logic [31:0] wd,
                    output logic [31:0] rdata, output logic err, output int lat);
    bit done;
    req = 1'b1; mem_write = we; byte_access = byt; address = a; write_data = wd;
    @(negedge clk);
    check("stall_on_req", 0, 32'(stl[0]), 32'd1);
    @(posedge clk); #1;
    req = 1'b0; mem_write = $urandom_range(0, 1); address = $urandom; write_data = $urandom;
    lat = 1; rdata = '0; err = 1'b0; done = 1'b0;
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge clk);
      if (rdy[0]) begin
        rdata = rd0; err = aerr[0]; done = 1'b1;
      end
      @(posedge clk); #1;
      if (!done) lat++;
    end
    if (!done) check("ready_timeout", 0, 32'd0, 32'd1);
  endtask

  logic [31:0] rdv;
  logic        errv;
  int          latv;
  logic [3:0]  rdy_pat, stl_pat;
  logic [31:0] rd_b2b;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req = 1'b0; mem_write = 1'b0; byte_access = 1'b0;
    address = '0; write_data = '0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;

    // fill RAM with known random words
    for (int a = 0; a < 256; a += 4) op(1'b1, 1'b0, 32'(a), $urandom, rdv, errv, latv);

    // reset held 3 cycles: all outputs 0
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rst_outputs", 0, {rd0[29:0], rdy[0], aerr[0]} | 32'(stl[0]), 32'd0);
      check("rst_outputs", 1, {rd1[29:0], rdy[1], aerr[1]} | 32'(stl[1]), 32'd0);
      @(posedge clk); #1;
    end
    reset = 1'b0;

    op(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, rdv, errv, latv);
    check("store_latency", 0, 32'(latv), 32'd3);
    check("store_err", 0, 32'(errv), 32'd0);
    op(1'b0, 1'b0, 32'h10, 32'h0, rdv, errv, latv);
    check("word_load", 0, rdv, 32'hDEADBEEF);
    op(1'b0, 1'b1, 32'h12, 32'h0, rdv, errv, latv);
    check("byte_load", 0, rdv, 32'h000000BE);

    op(1'b1, 1'b1, 32'h11, 32'h123456AA, rdv, errv, latv);
    op(1'b0, 1'b0, 32'h13, 32'h0, rdv, errv, latv);
    check("byte_store_word", 0, rdv, 32'hDEAABEEF);

    op(1'b1, 1'b0, 32'h100, 32'hCAFEF00D, rdv, errv, latv);
    check("oob_store_err", 0, 32'(errv), 32'd1);
    op(1'b0, 1'b0, 32'h100, 32'h0, rdv, errv, latv);
    check("oob_load_err", 0, 32'(errv), 32'd1);
    check("oob_load_data", 0, rdv, 32'd0);
    op(1'b0, 1'b0, 32'h10, 32'h0, rdv, errv, latv);
    check("ram_after_oob", 0, rdv, 32'hDEAABEEF);

    // back-to-back loads with req held high (zero-wait instance)
    req = 1'b1; mem_write = 1'b0; byte_access = 1'b0; address = 32'h10;
    rdy_pat = '0; stl_pat = '0; rd_b2b = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      rdy_pat[c] = rdy[1]; stl_pat[c] = stl[1];
      if (c == 1) rd_b2b = rd1;
      @(posedge clk); #1;
    end
    req = 1'b0;
    check("b2b_ready", 1, 32'(rdy_pat), 32'h0000000A);
    check("b2b_stall", 1, 32'(stl_pat), 32'h00000005);
    check("b2b_data", 1, rd_b2b, 32'hDEAABEEF);
    repeat (6) begin @(posedge clk); #1; end

    // reset in the first wait cycle abandons the store
    op(1'b1, 1'b0, 32'h20, 32'h11223344, rdv, errv, latv);
    req = 1'b1; mem_write = 1'b1; byte_access = 1'b0; address = 32'h20; write_data = 32'hFFFFFFFF;
    @(posedge clk); #1;
    req = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("no_ready_after_rst", 0, 32'(rdy[0]), 32'd0);
      @(posedge clk); #1;
    end
    op(1'b0, 1'b0, 32'h20, 32'h0, rdv, errv, latv);
    check("rst_store_dropped", 0, rdv, 32'h11223344);
    check("idle_after_rst", 0, 32'(latv), 32'd3);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      reset       = ($urandom_range(0, 149) == 0);
      req         = ($urandom_range(0, 2) != 0);
      mem_write   = $urandom_range(0, 1);
      byte_access = $urandom_range(0, 1);
      address     = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 263));
      write_data  = $urandom;
      @(posedge clk); #1;
    end
    reset = 1'b0; req = 1'b0;
    repeat (6) begin @(posedge clk); #1; end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
